// File: rtl/eth_types_pkg.sv
// Shared types and constants for the RMII receive path.
// CRC-32 constants use the reflected (LSB-first) Ethernet form.
package eth_types_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rmii_rx_states;

  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide next-state function of the reflected Ethernet CRC-32.
// Purely combinational; the caller owns the CRC register.
module eth_crc32
  import eth_types_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  input  logic        i_clear,
  input  logic        i_en,
  output logic [31:0] o_crc
);

  logic [31:0] w_step;

  always_comb begin
    w_step = i_crc ^ {24'h0, i_data};
    for (int i = 0; i < 8; i++) begin
      if (w_step[0])
        w_step = (w_step >> 1) ^ CRC32_POLY;
      else
        w_step = w_step >> 1;
    end
  end

  always_comb begin
    o_crc = i_crc;
    unique case (1'b1)
      i_clear: o_crc = CRC32_INIT;
      i_en:    o_crc = w_step;
      default: o_crc = i_crc;
    endcase
  end

endmodule

// File: rtl/eth_rmii_rx.sv
// RMII receiver: preamble/SFD hunt, dibit-to-byte assembly,
// LAN8720 crs_dv toggle handling and end-of-frame CRC/length check.
module eth_rmii_rx
  import eth_types_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1522
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       crs_dv,
  input  logic [1:0] rxd,
  input  logic       rx_er,
  output logic [7:0] received_byte,
  output logic       byte_valid,
  output logic       frame_ok,
  output logic       frame_err
);

  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

  rmii_rx_states r_state, w_state;
  logic [4:0]    r_pcnt, w_pcnt;
  logic [1:0]    r_idx, w_idx;
  logic          r_prov, w_prov;
  logic [5:0]    r_shift, w_shift;
  logic [15:0]   r_cnt, w_cnt;
  logic          r_err, w_err;
  logic          r_cdv;
  logic [31:0]   r_crc, w_crc;
  logic [7:0]    w_byte;
  logic          w_bv, w_ok, w_ferr;
  logic          w_crc_clr, w_crc_en;
  logic [1:0]    w_eidx;
  logic          w_bad;

  eth_crc32 u_crc (
    .i_crc   (r_crc),
    .i_data  ({rxd, r_shift}),
    .i_clear (w_crc_clr),
    .i_en    (w_crc_en),
    .o_crc   (w_crc)
  );

  // A provisional dibit has already advanced the index; undo it at EOF.
  assign w_eidx = r_prov ? r_idx - 2'd1 : r_idx;
  assign w_bad  = (r_crc != CRC32_RESIDUE) || (w_eidx != 2'd0) ||
                  (r_cnt < MIN_LEN) || (r_cnt > MAX_LEN) ||
                  r_err || rx_er;

  always_comb begin
    w_state   = r_state;
    w_pcnt    = r_pcnt;
    w_idx     = r_idx;
    w_prov    = r_prov;
    w_shift   = r_shift;
    w_cnt     = r_cnt;
    w_err     = r_err;
    w_byte    = received_byte;
    w_bv      = 1'b0;
    w_ok      = 1'b0;
    w_ferr    = 1'b0;
    w_crc_clr = 1'b0;
    w_crc_en  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (crs_dv) begin
          if (rxd == 2'b01) begin
            w_state = PREAMBLE;
            w_pcnt  = 5'd1;
          end else if (rxd != 2'b00) begin
            w_state = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!crs_dv) begin
          w_state = IDLE;
        end else if (rxd == 2'b01) begin
          if (r_pcnt != 5'd31) w_pcnt = r_pcnt + 5'd1;
        end else if (rxd == 2'b11 && r_pcnt >= 5'd3) begin
          w_state   = DATA;
          w_byte    = SFD_BYTE;
          w_bv      = 1'b1;
          w_idx     = 2'd0;
          w_prov    = 1'b0;
          w_cnt     = 16'd0;
          w_err     = 1'b0;
          w_crc_clr = 1'b1;
        end else begin
          w_state = DROP;
        end
      end
      DATA: begin
        if (rx_er) w_err = 1'b1;
        if (!crs_dv && (r_prov || r_idx[0])) begin
          w_state = IDLE;
          w_ok    = !w_bad;
          w_ferr  = w_bad;
          w_idx   = 2'd0;
          w_prov  = 1'b0;
        end else begin
          w_prov = !crs_dv;
          w_idx  = r_idx + 2'd1;
          unique case (r_idx)
            2'd0: w_shift[1:0] = rxd;
            2'd1: w_shift[3:2] = rxd;
            2'd2: w_shift[5:4] = rxd;
            2'd3: begin
              w_byte   = {rxd, r_shift};
              w_bv     = 1'b1;
              w_crc_en = 1'b1;
              if (r_cnt != 16'hFFFF) w_cnt = r_cnt + 16'd1;
            end
          endcase
        end
      end
      default: begin
        if (!crs_dv && !r_cdv) w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= DROP;
      r_pcnt        <= 5'd0;
      r_idx         <= 2'd0;
      r_prov        <= 1'b0;
      r_shift       <= 6'd0;
      r_cnt         <= 16'd0;
      r_err         <= 1'b0;
      r_cdv         <= 1'b1;
      r_crc         <= CRC32_INIT;
      received_byte <= 8'h00;
      byte_valid    <= 1'b0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_pcnt        <= w_pcnt;
      r_idx         <= w_idx;
      r_prov        <= w_prov;
      r_shift       <= w_shift;
      r_cnt         <= w_cnt;
      r_err         <= w_err;
      r_cdv         <= crs_dv;
      r_crc         <= w_crc;
      received_byte <= w_byte;
      byte_valid    <= w_bv;
      frame_ok      <= w_ok;
      frame_err     <= w_ferr;
    end
  end

endmodule
